// File: rtl/imm_encode.sv
// imm_encode: scatters a RISC-V immediate into instruction bits [31:7] behind one registered valid/ready stage.
// Optional representability checking is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm,
    input  logic [2:0]  sel,
    input  logic [24:0] other,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] enc,
    output logic        err,
    output logic [7:0]  err_cnt
);
    logic [24:0] enc_d;
    logic        sel_err;
    logic        range_err;
    logic        accept;

    always_comb begin
        enc_d   = other;
        sel_err = 1'b0;
        case (sel)
            3'd0, 3'd1: enc_d = {imm[11:0], other[12:0]};
            3'd2:       enc_d = {imm[11:5], other[17:5], imm[4:0]};
            3'd3:       enc_d = {imm[12], imm[10:5], other[17:5], imm[4:1], imm[11]};
            3'd4:       enc_d = {imm[31:12], other[4:0]};
            3'd5:       enc_d = {imm[20], imm[10:1], imm[11], imm[19:12], other[4:0]};
            default:    sel_err = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Upper bits must be a clean sign (or zero) extension; branch/jump offsets must be even.
    always_comb begin
        range_err = 1'b0;
        case (sel)
            3'd0, 3'd2: range_err = !(&imm[31:11] || ~|imm[31:11]);
            3'd1:       range_err = |imm[31:12];
            3'd3:       range_err = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
            3'd4:       range_err = |imm[11:0];
            3'd5:       range_err = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
            default:    range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            enc       <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                enc       <= enc_d;
                err       <= sel_err || range_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready && err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: directed self-checking bench for imm_encode.
// Expected err values follow IMM_RANGE_CHECK_EN when it is defined for the build.
module tb_imm_encode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] imm = '0;
    logic [2:0]  sel = '0;
    logic [24:0] other = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] enc;
    logic        err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    imm_encode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .sel(sel), .other(other), .out_valid(out_valid),
        .out_ready(out_ready), .enc(enc), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (enc !== 25'd0) begin fails++; $display("FAIL reset_enc got %h want 0", enc); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_formats();
        logic [2:0]  v_sel   [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd1};
        logic [31:0] v_imm   [12] = '{32'hFFFFF800, 32'h00000ABC, 32'h00000FFF, 32'h00000801, 32'hFFFFF000,
                                      32'h12345000, 32'h00000001, 32'h000FF7FE, 32'h00100000, 32'hFFFFFFFF,
                                      32'h00000000, 32'h00001000};
        logic [24:0] v_oth   [12] = '{25'h0, 25'h1FFFFFF, 25'h0, 25'h0, 25'h0, 25'h1F, 25'h0, 25'h1F, 25'h0,
                                      25'h1234567, 25'h0ABCDEF, 25'h0};
        logic [24:0] v_enc   [12] = '{25'h1000000, 25'h1579FFF, 25'h1FC001F, 25'h0000001, 25'h1000000,
                                      25'h02468BF, 25'h0000000, 25'h0FFDFFF, 25'h1000000, 25'h1234567,
                                      25'h0ABCDEF, 25'h0000000};
        logic        v_err   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        v_rerr  [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            sel = v_sel[i]; imm = v_imm[i]; other = v_oth[i];
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fmt%0d_out_valid got %b want 1", i, out_valid); end
            tests++; if (enc !== v_enc[i]) begin fails++; $display("FAIL fmt%0d_enc got %h want %h", i, enc, v_enc[i]); end
            tests++; if (err !== (RC ? v_rerr[i] : v_err[i])) begin fails++; $display("FAIL fmt%0d_err got %b want %b", i, err, RC ? v_rerr[i] : v_err[i]); end
            step();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fmt%0d_drain got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_imm [3] = '{32'h00000001, 32'h00000002, 32'h00000003};
        out_ready = 1'b1; sel = 3'd0; other = 25'h0;
        for (int i = 0; i < 3; i++) begin
            imm = b_imm[i]; in_valid = 1'b1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b%0d_in_ready got %b want 1", i, in_ready); end
            step();
            tests++; if (out_valid !== 1'b1 || enc !== (25'(b_imm[i][11:0]) << 13)) begin
                fails++; $display("FAIL b2b%0d_enc got %b/%h want 1/%h", i, out_valid, enc, 25'(b_imm[i][11:0]) << 13);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        sel = 3'd0; imm = 32'h00000123; other = 25'h0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        sel = 3'd4; imm = 32'hABCDE000;
        for (int i = 0; i < 3; i++) begin
            tests++; if (out_valid !== 1'b1 || enc !== 25'h0246000) begin fails++; $display("FAIL bp_hold%0d got %b/%h want 1/0246000", i, out_valid, enc); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || enc !== 25'h1579BC0) begin fails++; $display("FAIL bp_b got %b/%h want 1/1579BC0", out_valid, enc); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0; #1 rst_n = 1'b1;
        sel = 3'd7; other = 25'h0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            step();
            if (i == 255) begin
                tests++; if (err_cnt !== 8'd254) begin fails++; $display("FAIL sat_254 got %0d want 254", err_cnt); end
            end
            if (i == 256) begin
                tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_255 got %0d want 255", err_cnt); end
            end
        end
        tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_hold got %0d want 255", err_cnt); end
        // reset mid-stream, well clear of any clock edge
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_out_valid got %b want 0", out_valid); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL async_err_cnt got %0d want 0", err_cnt); end
        tests++; if (enc !== 25'd0 || err !== 1'b0) begin fails++; $display("FAIL async_enc_err got %h/%b want 0/0", enc, err); end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        sel = 3'd0; imm = 32'hFFFFF800; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || enc !== 25'h1000000 || err !== 1'b0) begin
            fails++; $display("FAIL post_reset got %b/%h/%b want 1/1000000/0", out_valid, enc, err);
        end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL post_reset_cnt got %0d want 0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
